// File: rtl/nn_pkg.sv
// Shared neural-stage definitions: MAC FSM states and accumulator sizing.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Product width plus growth bits for summing n lanes.
  function automatic int unsigned acc_width(int unsigned dw, int unsigned ww, int unsigned n);
    return dw + ww + 32'($clog2(n));
  endfunction

endpackage

// File: rtl/onehot_mac_unit_if.sv
// Lane-select, operand and valid/ready result bundle of the one-hot MAC stage.
interface onehot_mac_unit_if #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned WW = 8
);
  localparam int unsigned AW = nn_pkg::acc_width(DW, WW, N);

  logic [N-1:0]           sel;
  logic                   start;
  logic [N*DW-1:0]        x_flat;
  logic [N*WW-1:0]        w_flat;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [AW-1:0]   acc_out;
  logic                   sel_error;

  modport master (
    output sel, start, x_flat, w_flat, out_ready,
    input  busy, out_valid, acc_out, sel_error
  );

  modport slave (
    input  sel, start, x_flat, w_flat, out_ready,
    output busy, out_valid, acc_out, sel_error
  );

endinterface

// File: rtl/onehot_lane_select.sv
// Combinational lane product picked by a one-hot select; a malformed select
// yields a zero product and raises not_onehot_c.
module onehot_lane_select #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned WW = 8,
  parameter int unsigned AW = nn_pkg::acc_width(DW, WW, N)
) (
  input  logic [N-1:0]         sel,
  input  logic [N*DW-1:0]      x_flat,
  input  logic [N*WW-1:0]      w_flat,
  output logic signed [AW-1:0] product_c,
  output logic                 not_onehot_c
);

  localparam int unsigned PW = DW + WW;

  logic signed [AW-1:0] lane_prod [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [DW-1:0] x_l;
    logic signed [WW-1:0] w_l;
    logic signed [PW-1:0] p;
    assign x_l          = x_flat[i*DW +: DW];
    assign w_l          = w_flat[i*WW +: WW];
    assign p            = PW'(x_l) * PW'(w_l);
    assign lane_prod[i] = AW'(p);
  end

  always_comb begin
    product_c    = '0;
    not_onehot_c = ($countones(sel) != 1);
    for (int i = 0; i < N; i++) begin
      if (sel[i] && !not_onehot_c) product_c = lane_prod[i];
    end
  end

endmodule

// File: rtl/onehot_mac_unit.sv
// Ring-driven multiply-accumulate: one dot product of N lanes per ring
// rotation, presented on a valid/ready output.
module onehot_mac_unit
  import nn_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned WW = 8
) (
  input logic              clk,
  input logic              reset,
  onehot_mac_unit_if.slave bus
);

  localparam int unsigned AW = acc_width(DW, WW, N);
  localparam int unsigned CW = $clog2(N + 1);

  state_t               state;
  logic [CW-1:0]        count;
  logic                 pending;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_out;
  logic                 busy;
  logic                 out_valid;
  logic                 sel_error;

  logic signed [AW-1:0] product_c;
  logic                 not_onehot_c;
  logic                 accept_c;
  logic signed [AW-1:0] acc_sum_c;

  onehot_lane_select #(
    .N (N),
    .DW(DW),
    .WW(WW),
    .AW(AW)
  ) u_lane_select (
    .sel         (bus.sel),
    .x_flat      (bus.x_flat),
    .w_flat      (bus.w_flat),
    .product_c   (product_c),
    .not_onehot_c(not_onehot_c)
  );

  // A run may only begin on the rotation-start position of the ring.
  assign accept_c  = (pending || bus.start) && (bus.sel == N'(1));
  assign acc_sum_c = acc + product_c;

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      pending   <= 1'b0;
      acc       <= '0;
      acc_out   <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      sel_error <= 1'b0;
    end else begin
      if (bus.start) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (accept_c) begin
            acc       <= product_c;
            count     <= CW'(1);
            sel_error <= 1'b0;
            pending   <= 1'b0;
            if (N == 1) begin
              state     <= DONE;
              out_valid <= 1'b1;
              acc_out   <= product_c;
            end else begin
              state <= ACCUM;
              busy  <= 1'b1;
            end
          end
        end
        ACCUM: begin
          acc   <= acc_sum_c;
          count <= count + CW'(1);
          if (not_onehot_c) sel_error <= 1'b1;
          if (count == CW'(N - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            acc_out   <= acc_sum_c;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.acc_out   = acc_out;
  assign bus.sel_error = sel_error;

endmodule

// File: tb/tb_onehot_mac_unit.sv
// Self-checking bench for onehot_mac_unit: table vectors, random dot products
// against a lane-sum model, and hand-written multi-cycle sequences.
module tb_onehot_mac_unit;
  import nn_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned WW = 8;

  typedef struct {
    int     x[N];
    int     w[N];
    longint exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  onehot_mac_unit_if #(.N(N), .DW(DW), .WW(WW)) bus ();

  onehot_mac_unit #(.N(N), .DW(DW), .WW(WW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int ring_pos    = 0;
  bit force_sel   = 1'b0;

  // Ring visits bit 0, then N-1, N-2, ..., 1.
  function automatic logic [N-1:0] ring_sel(int pos);
    logic [N-1:0] one;
    int sh;
    one = N'(1);
    sh  = (int'(N) - pos) % int'(N);
    return one << sh;
  endfunction

  function automatic longint model(input int x[N], input int w[N]);
    longint s = 0;
    for (int i = 0; i < int'(N); i++) s += longint'(x[i]) * longint'(w[i]);
    return s;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ring_pos = (ring_pos + 1) % int'(N);
    if (!force_sel) bus.sel = ring_sel(ring_pos);
  endtask

  task automatic align(input int pos);
    for (int k = 0; k <= int'(N) && ring_pos != pos; k++) tick();
  endtask

  task automatic set_xw(input int x[N], input int w[N]);
    for (int i = 0; i < int'(N); i++) begin
      bus.x_flat[i*DW +: DW] = DW'(x[i]);
      bus.w_flat[i*WW +: WW] = WW'(w[i]);
    end
  endtask

  // One start pulse at the current ring position; checks latency, busy, result, hold, drain.
  task automatic run(input int x[N], input int w[N], input longint exp,
                     input string name, input int hold);
    int wait_c, n;
    bit busy_at;
    set_xw(x, w);
    wait_c  = (int'(N) - ring_pos) % int'(N);
    busy_at = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 4 * int'(N)) begin
      if (n == wait_c + 1) busy_at = bus.busy;
      tick();
      n++;
    end
    chk({name, " latency"}, n, wait_c + int'(N));
    chk({name, " busy"}, busy_at, 1);
    chk({name, " acc_out"}, bus.acc_out, exp);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({name, " hold valid"}, bus.out_valid, 1);
      chk({name, " hold acc"}, bus.acc_out, exp);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({name, " drained"}, bus.out_valid, 0);
  endtask

  initial begin
    vec_t   tbl[6];
    int     xa[N], wa[N];
    int     n;
    bit     seen;
    longint e;

    tbl[0].x = '{1, 2, 3};          tbl[0].w = '{4, 5, 6};          tbl[0].exp = 32;
    tbl[1].x = '{-128, -128, -128}; tbl[1].w = '{-128, -128, -128}; tbl[1].exp = 49152;
    tbl[2].x = '{127, 127, 127};    tbl[2].w = '{-128, -128, -128}; tbl[2].exp = -48768;
    tbl[3].x = '{-1, 0, 5};         tbl[3].w = '{7, 9, -3};         tbl[3].exp = -22;
    tbl[4].x = '{100, -50, 25};     tbl[4].w = '{2, 2, -4};         tbl[4].exp = 0;
    tbl[5].x = '{127, 127, 127};    tbl[5].w = '{127, 127, 127};    tbl[5].exp = 48387;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_flat    = '0;
    bus.w_flat    = '0;
    bus.sel       = ring_sel(0);
    tick();
    tick();
    chk("reset busy", bus.busy, 0);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset acc_out", bus.acc_out, 0);
    chk("reset sel_error", bus.sel_error, 0);
    reset = 1'b0;
    tick();

    // Table vectors, starting from each ring position in turn.
    for (int i = 0; i < 6; i++) begin
      align(i % int'(N));
      run(tbl[i].x, tbl[i].w, tbl[i].exp, $sformatf("vec%0d", i), (i == 0) ? 5 : 1);
    end

    // Random operands and ring offsets against the lane-sum model.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < int'(N); i++) begin
        xa[i] = int'($urandom_range(0, 255)) - 128;
        wa[i] = int'($urandom_range(0, 255)) - 128;
      end
      n = int'($urandom_range(0, 2));
      for (int k = 0; k < n; k++) tick();
      run(xa, wa, model(xa, wa), $sformatf("rand%0d", r), int'($urandom_range(0, 3)));
    end

    // Malformed select on the second run cycle: that lane contributes nothing.
    xa = '{1, 2, 3};
    wa = '{4, 5, 6};
    set_xw(xa, wa);
    align(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    force_sel = 1'b1;
    bus.sel   = 3'b011;
    tick();
    force_sel = 1'b0;
    bus.sel   = ring_sel(ring_pos);
    tick();
    chk("selerr valid", bus.out_valid, 1);
    chk("selerr acc_out", bus.acc_out, 14);
    chk("selerr flag", bus.sel_error, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("selerr sticky", bus.sel_error, 1);
    align(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("selerr cleared", bus.sel_error, 0);
    n = 0;
    while (!bus.out_valid && n < 4 * int'(N)) begin tick(); n++; end
    chk("selerr rerun acc", bus.acc_out, 32);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Extra starts during a run collapse into one queued run.
    xa = '{-7, 11, 3};
    wa = '{9, -2, 40};
    e  = model(xa, wa);
    set_xw(xa, wa);
    align(0);
    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    tick();
    chk("pend first valid", bus.out_valid, 1);
    chk("pend first acc", bus.acc_out, e);
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    chk("pend released", bus.out_valid, 0);
    n = 0;
    while (!bus.out_valid && n < 4 * int'(N)) begin tick(); n++; end
    chk("pend second latency", n, 2 * int'(N) - 1);
    chk("pend second acc", bus.acc_out, e);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 2 * int'(N); k++) begin tick(); seen |= bus.busy; end
    chk("pend no third run", seen, 0);

    // Reset one cycle after accept aborts the run.
    align(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("abort busy before", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", bus.busy, 0);
    chk("abort acc_out", bus.acc_out, 0);
    chk("abort out_valid", bus.out_valid, 0);
    seen = 1'b0;
    for (int k = 0; k < 2 * int'(N); k++) begin tick(); seen |= bus.out_valid; end
    chk("abort no valid", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
